free_to_one_of_n_arb: RTL and testbench

Clocked, parametrised arbiter that merges N free-running four-phase request channels into one 1-of-N output code with NCL-style completion handshakes. Sits at the boundary between clockless request sources and a clocked consumer. Generalises the fixed three-channel free-to-trinary merge to N channels, with input synchronisation, selectable fixed-priority or round-robin arbitration, and optional per-channel grant statistics.

---
 rtl/free_to_one_of_n_arb_pkg.sv | 45 ++++
 rtl/free_to_one_of_n_arb_if.sv | 18 +
 rtl/free_arb_sync.sv | 33 +++
 rtl/free_to_one_of_n_arb.sv | 126 ++++++++++++
 tb/tb_free_to_one_of_n_arb.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/free_to_one_of_n_arb_pkg.sv
// free_arb_pkg: shared types and winner-selection helpers for the
// free_to_one_of_n_arb slice.
//   state_t : arbiter FSM states (IDLE, GRANT, NULLW)
//   fp_pick : fixed priority, lowest asserted index wins (one-hot result)
//   rr_pick : round robin starting at ptr, wrapping modulo n (one-hot result)
// Request vectors are carried at N_MAX width; unused upper bits must be zero.
package free_arb_pkg;

  localparam int N_MAX = 16;
  localparam int PTR_W = $clog2(N_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    NULLW = 2'd2
  } state_t;

  // Isolate the lowest set bit: req & -req.
  function automatic logic [N_MAX-1:0] fp_pick(input logic [N_MAX-1:0] req);
    return req & (~req + N_MAX'(1));
  endfunction

  // First asserted channel at or after ptr, wrapping at n (n is the live
  // channel count, not N_MAX).
  function automatic logic [N_MAX-1:0] rr_pick(input logic [N_MAX-1:0] req,
                                               input logic [PTR_W-1:0] ptr,
                                               input int n);
    logic [N_MAX-1:0] win;
    logic [PTR_W-1:0] idx;
    bit               found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_MAX; k++) begin
      if (k < n && !found) begin
        idx = PTR_W'((int'(ptr) + k) % n);
        if (req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/free_to_one_of_n_arb_if.sv
// Handshake bundle between N free-running four-phase request sources, the
// arbiter and the downstream 1-of-N consumer.
//   inR      : request rails, one per channel
//   RCOMP    : per-channel completion back to the sources (== out_rail)
//   out_rail : 1-of-N output code, all-zero = NULL
//   outCOMP  : downstream completion (low = ready for DATA, high = ready for NULL)
// Modports: slave = arbiter side, master = environment side.
interface free_to_one_of_n_arb_if #(
  parameter int N = 4
);
  logic [N-1:0] inR;
  logic [N-1:0] RCOMP;
  logic [N-1:0] out_rail;
  logic         outCOMP;

  modport slave  (input  inR, outCOMP, output RCOMP, out_rail);
  modport master (output inR, outCOMP, input  RCOMP, out_rail);
endinterface

// File: rtl/free_arb_sync.sv
// free_arb_sync: STAGES-deep flop chain per bit, cleared by init.
// STAGES = 0 turns the block into a plain wire passthrough.
// Ports: clk, init (async, active-high), d[W] in, q[W] out.
module free_arb_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         init,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_init;
    assign unused_clk_init = clk ^ init;
    assign q = d;
  end else begin : g_chain
    logic [W-1:0] stg [STAGES];

    always_ff @(posedge clk or posedge init) begin
      if (init) begin
        for (int k = 0; k < STAGES; k++) stg[k] <= '0;
      end else begin
        stg[0] <= d;
        for (int k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
      end
    end

    assign q = stg[STAGES-1];
  end

endmodule

// File: rtl/free_to_one_of_n_arb.sv
// free_to_one_of_n_arb: merges N free-running four-phase request channels
// into one registered 1-of-N code with NCL-style completion handshakes.
//   clk, init   : clock and asynchronous active-high reset
//   arb         : handshake bundle (inR, RCOMP, out_rail, outCOMP)
//   cnt_clr     : synchronous clear of grant counters   (FREE_ARB_CNT_EN)
//   grant_cnt   : saturating per-channel grant counters (FREE_ARB_CNT_EN),
//                 channel i at [i*CNT_W +: CNT_W]
// Optional feature macro: FREE_ARB_CNT_EN.
// FSM: IDLE -> GRANT (winner registered) -> NULLW (wait outCOMP low) -> IDLE.
module free_to_one_of_n_arb
  import free_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RR          = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 init,
`ifdef FREE_ARB_CNT_EN
  input  logic                 cnt_clr,
  output logic [N*CNT_W-1:0]   grant_cnt,
`endif
  free_to_one_of_n_arb_if.slave arb
);

  logic [N-1:0]     req_s;
  logic             comp_s;
  logic [N-1:0]     out_q;
  logic [PTR_W-1:0] ptr;
  state_t           state;

  logic [N_MAX-1:0] win_all;
  logic [N-1:0]     win;
  logic [PTR_W-1:0] gidx_nxt;
  logic             take;
  logic             release_ok;

  // Input synchroniser stage boundary: requests and downstream completion.
  free_arb_sync #(
    .W      (N + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .init (init),
    .d    ({arb.outCOMP, arb.inR}),
    .q    ({comp_s, req_s})
  );

  always_comb begin
    win_all = (RR != 0) ? rr_pick(N_MAX'(req_s), ptr, N) : fp_pick(N_MAX'(req_s));
  end
  assign win = N'(win_all);

  always_comb begin
    gidx_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) gidx_nxt = PTR_W'(i);
    end
  end

  assign take = (state == IDLE) && !comp_s && (|req_s);
  // out_q is one-hot(g) while in GRANT, so masking it selects inR[g].
  assign release_ok = !(|(req_s & out_q)) && comp_s;

  // Arbitration / output register stage boundary.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state <= IDLE;
      ptr   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            out_q <= win;
            state <= GRANT;
            if (RR != 0) begin
              ptr <= (gidx_nxt == PTR_W'(N - 1)) ? '0 : gidx_nxt + PTR_W'(1);
            end
          end
        end
        GRANT: begin
          if (release_ok) begin
            out_q <= '0;
            state <= NULLW;
          end
        end
        NULLW: begin
          if (!comp_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.out_rail = out_q;
  assign arb.RCOMP    = out_q;

`ifdef FREE_ARB_CNT_EN
  logic [CNT_W-1:0] cnt [N];

  // Grant counter stage boundary: clear beats a coincident increment.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cnt_clr) begin
          cnt[i] <= '0;
        end else if (take && win[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_cnt_out
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_free_to_one_of_n_arb.sv
// Directed bench for free_to_one_of_n_arb: a round-robin instance and a
// fixed-priority instance (both N=4, SYNC_STAGES=2, CNT_W=2).
module tb_free_to_one_of_n_arb;

  logic clk;
  logic init;
  int   checks;
  int   errors;
  int   onehot_viol;

  free_to_one_of_n_arb_if #(.N(4)) rr_if ();
  free_to_one_of_n_arb_if #(.N(4)) fp_if ();

`ifdef FREE_ARB_CNT_EN
  logic       rr_clr, fp_clr;
  logic [7:0] rr_cnt, fp_cnt;
`endif

  free_to_one_of_n_arb #(.N(4), .SYNC_STAGES(2), .RR(1), .CNT_W(2)) dut_rr (
    .clk       (clk),
    .init      (init),
`ifdef FREE_ARB_CNT_EN
    .cnt_clr   (rr_clr),
    .grant_cnt (rr_cnt),
`endif
    .arb       (rr_if.slave)
  );

  free_to_one_of_n_arb #(.N(4), .SYNC_STAGES(2), .RR(0), .CNT_W(2)) dut_fp (
    .clk       (clk),
    .init      (init),
`ifdef FREE_ARB_CNT_EN
    .cnt_clr   (fp_clr),
    .grant_cnt (fp_cnt),
`endif
    .arb       (fp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!$onehot0(rr_if.out_rail) || !$onehot0(fp_if.out_rail)) onehot_viol++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    init = 1'b1;
    rr_if.inR = '0; rr_if.outCOMP = 1'b0;
    fp_if.inR = '0; fp_if.outCOMP = 1'b0;
    tick(2);
    init = 1'b0;
    tick(1);
  endtask

  // One full four-phase round on the RR instance: wait for grant, source
  // drops its rail, downstream completes, then (optionally) re-request.
  task automatic rr_grant(input string tag, input logic [3:0] exp, input bit restore);
    int n;
    n = 0;
    while (rr_if.out_rail == '0 && n < 20) begin tick(1); n++; end
    check({tag, "_grant"}, 32'(rr_if.out_rail), 32'(exp));
    check({tag, "_rcomp"}, 32'(rr_if.RCOMP), 32'(exp));
    rr_if.inR     = rr_if.inR & ~exp;
    rr_if.outCOMP = 1'b1;
    n = 0;
    while (rr_if.out_rail != '0 && n < 20) begin tick(1); n++; end
    check({tag, "_release"}, 32'(rr_if.out_rail), 32'h0);
    rr_if.outCOMP = 1'b0;
    if (restore) rr_if.inR = rr_if.inR | exp;
    tick(4);
  endtask

  initial begin
    checks = 0; errors = 0; onehot_viol = 0;
`ifdef FREE_ARB_CNT_EN
    rr_clr = 1'b0; fp_clr = 1'b0;
`endif
    do_reset();
    check("reset_out", 32'(rr_if.out_rail), 32'h0);
    check("reset_rcomp", 32'(rr_if.RCOMP), 32'h0);
    check("reset_ptr", 32'(dut_rr.ptr), 32'h0);

    // Latency: grant 3 cycles after request, release 3 cycles after nulling.
    rr_if.inR = 4'b0100;
    tick(2); check("lat_early", 32'(rr_if.out_rail), 32'h0);
    tick(1); check("lat_rise", 32'(rr_if.out_rail), 32'h4);
    check("lat_rcomp", 32'(rr_if.RCOMP), 32'h4);
    rr_if.outCOMP = 1'b1; rr_if.inR = 4'b0000;
    tick(2); check("lat_hold", 32'(rr_if.out_rail), 32'h4);
    tick(1); check("lat_fall", 32'(rr_if.out_rail), 32'h0);
    rr_if.outCOMP = 1'b0;
    tick(4);

    // Round-robin order with all channels continuously re-requesting.
    do_reset();
    rr_if.inR = 4'b1111;
    rr_grant("rr0", 4'b0001, 1'b1);
    rr_grant("rr1", 4'b0010, 1'b1);
    rr_grant("rr2", 4'b0100, 1'b1);
    rr_grant("rr3", 4'b1000, 1'b1);
    rr_grant("rr4", 4'b0001, 1'b0);
    rr_if.inR = '0;
    tick(4);

    // Fixed priority: channel 1 always beats channel 3.
    fp_if.inR = 4'b1010;
    for (int r = 0; r < 3; r++) begin
      int n;
      n = 0;
      while (fp_if.out_rail == '0 && n < 20) begin tick(1); n++; end
      check($sformatf("fp_grant%0d", r), 32'(fp_if.out_rail), 32'h2);
      fp_if.inR[1] = 1'b0; fp_if.outCOMP = 1'b1;
      n = 0;
      while (fp_if.out_rail != '0 && n < 20) begin tick(1); n++; end
      check($sformatf("fp_release%0d", r), 32'(fp_if.out_rail), 32'h0);
      fp_if.outCOMP = 1'b0; fp_if.inR[1] = 1'b1;
      tick(4);
    end
    fp_if.inR = '0;

    // outCOMP high early: output must hold until the request itself drops.
    do_reset();
    rr_if.inR = 4'b0001;
    tick(3); check("hold_grant", 32'(rr_if.out_rail), 32'h1);
    rr_if.outCOMP = 1'b1;
    tick(6); check("hold_comp_only", 32'(rr_if.out_rail), 32'h1);
    rr_if.inR = 4'b0000;
    tick(2); check("hold_sync", 32'(rr_if.out_rail), 32'h1);
    tick(1); check("hold_fall", 32'(rr_if.out_rail), 32'h0);
    rr_if.outCOMP = 1'b0;
    tick(4);

    // Asynchronous reset in the middle of a grant.
    rr_if.inR = 4'b0100;
    tick(3); check("mid_grant", 32'(rr_if.out_rail), 32'h4);
    check("mid_ptr", 32'(dut_rr.ptr), 32'h3);
    init = 1'b1;
    #1;
    check("init_out", 32'(rr_if.out_rail), 32'h0);
    check("init_rcomp", 32'(rr_if.RCOMP), 32'h0);
    check("init_state", 32'(dut_rr.state), 32'h0);
    check("init_ptr", 32'(dut_rr.ptr), 32'h0);
    rr_if.inR = 4'b1111;
    tick(2);
    check("init_held", 32'(rr_if.out_rail), 32'h0);
    init = 1'b0;
    rr_grant("post_init", 4'b0001, 1'b0);
    rr_if.inR = '0;
    tick(4);

`ifdef FREE_ARB_CNT_EN
    // Saturating counter and clear-beats-increment.
    do_reset();
    check("cnt_reset", 32'(rr_cnt), 32'h0);
    for (int g = 0; g < 5; g++) begin
      rr_if.inR = 4'b0100;
      rr_grant($sformatf("cnt%0d", g), 4'b0100, 1'b0);
    end
    check("cnt_sat", 32'(rr_cnt[4 +: 2]), 32'h3);
    check("cnt_others", 32'({rr_cnt[7:6], rr_cnt[3:0]}), 32'h0);
    rr_if.inR = 4'b0100;
    tick(2);
    rr_clr = 1'b1;
    tick(1);
    rr_clr = 1'b0;
    check("clr_grant", 32'(rr_if.out_rail), 32'h4);
    check("clr_wins", 32'(rr_cnt[4 +: 2]), 32'h0);
    rr_grant("clr_tail", 4'b0100, 1'b0);
`endif

    check("onehot0", 32'(onehot_viol), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
